bram_rd_arb: RTL and testbench

//  Arbitrates nports stream-consumer read ports onto the single read port of the L1 BRAM buffer
//  (bram_top). Round-robin grant; one request per cycle max. In-order port-ID tag FIFO routes

---
 rtl/msb_pkg.sv | 35 +++
 rtl/bram_rd_arb_tagq.sv | 53 +++++
 rtl/bram_rd_arb.sv | 165 ++++++++++++++++
 tb/tb_bram_rd_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/msb_pkg.sv
// Shared types for the L1 BRAM read arbiter: request layout, port-id type and lock state.
package msb_pkg;

    localparam int NPORTS    = 4;
    localparam int CHANNELS  = 2;
    localparam int L1_NSTRMS = 16;
    localparam int L1_NCL    = 16;
    localparam int WAYS      = 8;

    localparam int CH_W = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;
    localparam int ST_W = (L1_NSTRMS > 1) ? $clog2(L1_NSTRMS) : 1;
    localparam int CL_W = (L1_NCL    > 1) ? $clog2(L1_NCL)    : 1;
    localparam int OF_W = (WAYS      > 1) ? $clog2(WAYS)      : 1;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [ST_W-1:0] st;
        logic [CL_W-1:0] cl;
        logic [OF_W-1:0] of;
    } rd_req_t;

    localparam int req_w = $bits(rd_req_t);

    typedef logic [$clog2(NPORTS)-1:0] port_id_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/bram_rd_arb_tagq.sv
// In-order tag FIFO: remembers which port issued each outstanding BRAM read.
module bram_rd_arb_tagq
    import msb_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, wp_d;
    logic [AW:0]  rp_q, rp_d;
    logic         do_push, do_pop;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign head    = mem_q[rp_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (do_push) wp_d = wp_q + (AW+1)'(1);
        if (do_pop)  rp_d = rp_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bram_rd_arb.sv
// Round-robin arbiter of consumer read ports onto the single bram_top read port, with tag-routed responses.
// Optional BRAM_RD_ARB_PERF_EN adds per-port grant counters (o_gcnt) and a full-stall counter (o_stall).
module bram_rd_arb
    import msb_pkg::*;
#(
    parameter int nports     = NPORTS,
    parameter int DATA_WIDTH = 64,
    parameter int tag_depth  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [nports-1:0]       i_v,
    output logic [nports-1:0]       i_r,
    input  logic [nports*req_w-1:0] i_ra,
    output logic                    m_v,
    input  logic                    m_r,
    output logic [req_w-1:0]        m_ra,
    input  logic                    s_v,
    output logic                    s_r,
    input  logic [2*DATA_WIDTH-1:0] s_rd,
    input  logic [CH_W+ST_W-1:0]    s_ra,
    output logic [nports-1:0]       o_v,
    input  logic [nports-1:0]       o_r,
    output logic [2*DATA_WIDTH-1:0] o_rd,
    output logic [CH_W+ST_W-1:0]    o_ra,
    output logic                    o_err
`ifdef BRAM_RD_ARB_PERF_EN
    ,
    output logic [nports*32-1:0]    o_gcnt,
    output logic [31:0]             o_stall
`endif
);

    localparam int PW = (nports > 1) ? $clog2(nports) : 1;
    typedef logic [PW-1:0] pid_t;

    arb_state_e state_q, state_d;
    pid_t       lock_idx_q, lock_idx_d;
    pid_t       rr_ptr_q, rr_ptr_d;
    pid_t       grant, rr_pick, idx_p;
    pid_t       head;
    logic       found, any_v, fifo_full, fifo_empty, accept, pop;
    logic       o_err_q, o_err_d;
    int         idx;

    assign any_v = |i_v;

    // Cyclic search starting at rr_ptr; a pending (locked) grant overrides it.
    always_comb begin
        rr_pick = rr_ptr_q;
        found   = 1'b0;
        idx     = 0;
        idx_p   = '0;
        for (int k = 0; k < nports; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= nports) idx = idx - nports;
            idx_p = pid_t'(idx);
            if (!found && i_v[idx_p]) begin
                rr_pick = idx_p;
                found   = 1'b1;
            end
        end
        grant = (state_q == ARB_LOCKED) ? lock_idx_q : rr_pick;
    end

    assign m_v    = any_v && !fifo_full && !reset;
    assign m_ra   = i_ra[int'(grant)*req_w +: req_w];
    assign accept = m_v && m_r;

    always_comb begin
        i_r        = '0;
        i_r[grant] = m_r && !fifo_full && !reset;
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ARB_OPEN: begin
                if (m_v && !m_r) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = grant;
                end
            end
            ARB_LOCKED: begin
                if (accept) state_d = ARB_OPEN;
            end
            default: state_d = ARB_OPEN;
        endcase
        if (accept) rr_ptr_d = pid_t'(wrap_inc(int'(grant), nports));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_OPEN;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    bram_rd_arb_tagq #(
        .W     (PW),
        .DEPTH (tag_depth)
    ) u_tagq (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (grant),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Response path is pure steering: data/addr broadcast, valid/ready routed by FIFO head.
    always_comb begin
        o_v       = '0;
        o_v[head] = s_v && !fifo_empty && !reset;
    end

    assign s_r  = o_r[head] && !fifo_empty && !reset;
    assign pop  = s_v && s_r;
    assign o_rd = s_rd;
    assign o_ra = s_ra;

    assign o_err_d = o_err_q || (s_v && fifo_empty);

    always_ff @(posedge clk) begin
        if (reset) o_err_q <= 1'b0;
        else       o_err_q <= o_err_d;
    end

    assign o_err = o_err_q;

`ifdef BRAM_RD_ARB_PERF_EN
    logic [nports-1:0][31:0] gcnt_q, gcnt_d;
    logic [31:0]             stall_q, stall_d;

    always_comb begin
        gcnt_d  = gcnt_q;
        stall_d = stall_q;
        if (accept)                gcnt_d[grant] = gcnt_q[grant] + 32'd1;
        if (any_v && fifo_full)    stall_d       = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            gcnt_q  <= gcnt_d;
            stall_q <= stall_d;
        end
    end

    assign o_gcnt  = gcnt_q;
    assign o_stall = stall_q;
`endif

endmodule

// File: tb/tb_bram_rd_arb.sv
// Directed bench for bram_rd_arb: expected grants/responses queued by stimulus, checked by a monitor.
module tb_bram_rd_arb;
    import msb_pkg::*;

    localparam int NP  = 4;
    localparam int DW  = 64;
    localparam int RW  = req_w;
    localparam int SAW = CH_W + ST_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     i_v, i_r, o_v, o_r;
    logic [NP*RW-1:0]  i_ra;
    logic              m_v, m_r, s_v, s_r, o_err;
    logic [RW-1:0]     m_ra;
    logic [2*DW-1:0]   s_rd, o_rd;
    logic [SAW-1:0]    s_ra, o_ra;
`ifdef BRAM_RD_ARB_PERF_EN
    logic [NP*32-1:0]  o_gcnt;
    logic [31:0]       o_stall;
`endif

    typedef struct {
        int             port;
        logic [2*DW-1:0] rd;
        logic [SAW-1:0] ra;
    } rsp_t;

    int          exp_req[$];
    rsp_t        exp_rsp[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [RW-1:0] ra_tab [NP];

    bram_rd_arb #(.nports(NP), .DATA_WIDTH(DW), .tag_depth(8)) dut (
        .clk(clk), .reset(reset),
        .i_v(i_v), .i_r(i_r), .i_ra(i_ra),
        .m_v(m_v), .m_r(m_r), .m_ra(m_ra),
        .s_v(s_v), .s_r(s_r), .s_rd(s_rd), .s_ra(s_ra),
        .o_v(o_v), .o_r(o_r), .o_rd(o_rd), .o_ra(o_ra),
        .o_err(o_err)
`ifdef BRAM_RD_ARB_PERF_EN
        , .o_gcnt(o_gcnt), .o_stall(o_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] dat(input int k);
        return {64'hC0DE_0000_0000_0000 + 64'(k), 64'h5A5A_0000_0000_0000 + 64'(k)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input int p, input int k);
        rsp_t r;
        s_v  = 1'b1;
        s_rd = dat(k);
        s_ra = SAW'(k);
        r.port = p;
        r.rd   = dat(k);
        r.ra   = SAW'(k);
        exp_rsp.push_back(r);
    endtask

    // Monitor: every handshake on either side consumes one queued expectation.
    initial begin
        int   p;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m_v && m_r) begin
                    if (exp_req.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_accept: i_r=%b expected none", i_r);
                    end else begin
                        p = exp_req.pop_front();
                        chk("grant_onehot", 128'(i_r), 128'(1) << p);
                        chk("m_ra", 128'(m_ra), 128'(ra_tab[p]));
                    end
                end
                if (|(o_v & o_r)) begin
                    if (exp_rsp.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_rsp: o_v=%b expected none", o_v);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_o_v", 128'(o_v), 128'(1) << r.port);
                        chk("rsp_o_rd", o_rd, r.rd);
                        chk("rsp_o_ra", 128'(o_ra), 128'(r.ra));
                        chk("rsp_s_r", 128'(s_r), 128'(1));
                    end
                end
            end
        end
    end

    initial begin
        ra_tab[0] = RW'(12'h123);
        ra_tab[1] = RW'(12'h456);
        ra_tab[2] = RW'(12'h789);
        ra_tab[3] = RW'(12'hABC);
        for (int p = 0; p < NP; p++) i_ra[p*RW +: RW] = ra_tab[p];
        o_r = '0; s_rd = '0; s_ra = '0;

        // Reset with everything asserted: outputs must stay quiet
        reset = 1'b1; i_v = '1; m_r = 1'b1; s_v = 1'b1;
        cyc(); cyc(); #2;
        chk("rst_m_v", 128'(m_v), 0);
        chk("rst_i_r", 128'(i_r), 0);
        chk("rst_o_v", 128'(o_v), 0);
        chk("rst_s_r", 128'(s_r), 0);
        chk("rst_o_err", 128'(o_err), 0);

        // All ports requesting: 0,1,2,3,0
        cyc(); reset = 1'b0; s_v = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            exp_req.push_back(k % 4);
        end
        cyc(); i_v = '0; o_r = '1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            rsp(k % 4, k);
        end
        cyc(); s_v = 1'b0;

        // Lock: port 2 stalled, port 0 joins, port 2 must still win
        cyc(); reset = 1'b1; i_v = '0; m_r = 1'b0;
        cyc(); reset = 1'b0; i_v = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            #2;
            chk("stall_m_v", 128'(m_v), 1);
            chk("stall_m_ra", 128'(m_ra), 128'(ra_tab[2]));
            chk("stall_i_r", 128'(i_r), 0);
        end
        cyc(); i_v = 4'b0101; #2;
        chk("lock_m_ra", 128'(m_ra), 128'(ra_tab[2]));
        cyc(); m_r = 1'b1; exp_req.push_back(2);
        cyc(); i_v = 4'b0001; exp_req.push_back(0);

        // Fill the tag FIFO with back-to-back grants to port 1
        for (int k = 0; k < 6; k++) begin
            cyc(); i_v = 4'b0010; exp_req.push_back(1);
        end
        cyc(); #2;
        chk("full_m_v", 128'(m_v), 0);
        chk("full_i_r", 128'(i_r), 0);
        cyc(); o_r = '1; rsp(2, 10); #2;
        chk("full_pop_m_v", 128'(m_v), 0);
        cyc(); s_v = 1'b0; exp_req.push_back(1); #2;
        chk("after_pop_m_v", 128'(m_v), 1);
        cyc(); i_v = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            rsp((k == 0) ? 0 : 1, 20 + k);
        end
        cyc(); s_v = 1'b0;

        // Tags {1,3,1} with port 3 not ready
        cyc(); i_v = 4'b0010; exp_req.push_back(1);
        cyc(); i_v = 4'b1000; exp_req.push_back(3);
        cyc(); i_v = 4'b0010; exp_req.push_back(1);
        cyc(); i_v = '0; o_r = 4'b0111; rsp(1, 30);
        for (int k = 0; k < 2; k++) begin
            cyc(); s_v = 1'b1; s_rd = dat(31); s_ra = SAW'(31); #2;
            chk("hol_s_r", 128'(s_r), 0);
            chk("hol_o_v", 128'(o_v), 128'(4'b1000));
        end
        cyc(); o_r = '1; rsp(3, 31);
        cyc(); rsp(1, 32);
        cyc(); s_v = 1'b0;

        // Response with no outstanding tag
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; s_v = 1'b1; #2;
        chk("err_s_r", 128'(s_r), 0);
        chk("err_o_v", 128'(o_v), 0);
        chk("err_pre", 128'(o_err), 0);
        cyc(); s_v = 1'b0; #2;
        chk("err_set", 128'(o_err), 1);
        cyc(); cyc(); #2;
        chk("err_sticky", 128'(o_err), 1);

`ifdef BRAM_RD_ARB_PERF_EN
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; i_v = '1; m_r = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            exp_req.push_back(k % 4);
        end
        cyc(); i_v = '0; #2;
        for (int p = 0; p < NP; p++) chk("gcnt", 128'(o_gcnt[p*32 +: 32]), 2);
        chk("stall", 128'(o_stall), 0);
`endif

        for (int t = 0; t < 20 && (exp_req.size() != 0 || exp_rsp.size() != 0); t++) cyc();
        chk("req_queue_drained", 128'(exp_req.size()), 0);
        chk("rsp_queue_drained", 128'(exp_rsp.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
